// File: rtl/scale_fifo_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scale_fifo_mc : multi-channel show-ahead FIFO of FP scale tiles, each    |
// | entry served cfg_reuse_i+1 times before it pops.      Rev 1.0            |
// +--------------------------------------------------------------------------+
module scale_fifo_mc #(
  parameter int MAT_SIZE      = 16,
  parameter int FP_MANT_W     = 23,
  parameter int FP_EXP_W      = 8,
  parameter int DEPTH         = 4,
  parameter int NUM_CH        = 2,
  parameter int REUSE_W       = 4,
  parameter int AFULL_MARGIN  = 1,
  parameter int AEMPTY_MARGIN = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LV_W = $clog2(DEPTH + 1),
  localparam int MW   = FP_MANT_W * MAT_SIZE * MAT_SIZE,
  localparam int EW   = FP_EXP_W * MAT_SIZE * MAT_SIZE
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   wr_valid_i,
  input  logic [CH_W-1:0]        wr_ch_i,
  output logic                   wr_ready_o,
  input  logic [MW-1:0]          mant_in_i,
  input  logic [EW-1:0]          exp_in_i,
  input  logic [CH_W-1:0]        rd_ch_i,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic                   rd_last_o,
  output logic [MW-1:0]          mant_out_o,
  output logic [EW-1:0]          exp_out_o,
  input  logic [REUSE_W-1:0]     cfg_reuse_i,
  input  logic [NUM_CH-1:0]      flush_i,
  output logic [NUM_CH*LV_W-1:0] level_o,
  output logic [NUM_CH-1:0]      empty_o,
  output logic [NUM_CH-1:0]      full_o,
  output logic [NUM_CH-1:0]      almost_empty_o,
  output logic [NUM_CH-1:0]      almost_full_o
);

  localparam int               PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CH_W:0]    c_num_ch    = (CH_W + 1)'(NUM_CH);
  localparam logic [PTR_W-1:0] c_last_ptr  = PTR_W'(DEPTH - 1);
  localparam logic [LV_W-1:0]  c_depth_lv  = LV_W'(DEPTH);
  localparam logic [LV_W-1:0]  c_afull_lv  = LV_W'((DEPTH > AFULL_MARGIN) ? (DEPTH - AFULL_MARGIN) : 0);
  localparam logic [LV_W-1:0]  c_aempty_lv = LV_W'((AEMPTY_MARGIN < DEPTH) ? AEMPTY_MARGIN : DEPTH);

  logic [PTR_W-1:0]   r_head  [NUM_CH];
  logic [PTR_W-1:0]   r_tail  [NUM_CH];
  logic [LV_W-1:0]    r_level [NUM_CH];
  logic [REUSE_W-1:0] r_rcnt  [NUM_CH];
  logic [MW-1:0]      r_mant  [NUM_CH][DEPTH];
  logic [EW-1:0]      r_exp   [NUM_CH][DEPTH];

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [CH_W-1:0]   w_wr_idx;
  logic [CH_W-1:0]   w_rd_idx;
  logic              w_push;
  logic              w_rd;
  logic              w_last;
  logic              w_pop;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_push_v;
  logic [NUM_CH-1:0] w_rd_v;
  logic [NUM_CH-1:0] w_pop_v;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == c_last_ptr) ? '0 : p + PTR_W'(1);
  endfunction

  // Out-of-range channel selects are folded to channel 0 for indexing and
  // masked off by the *_ok qualifiers.
  assign w_wr_ok  = {1'b0, wr_ch_i} < c_num_ch;
  assign w_rd_ok  = {1'b0, rd_ch_i} < c_num_ch;
  assign w_wr_idx = w_wr_ok ? wr_ch_i : '0;
  assign w_rd_idx = w_rd_ok ? rd_ch_i : '0;

  assign wr_ready_o = w_wr_ok & ~w_full[w_wr_idx];
  assign rd_valid_o = w_rd_ok & ~w_empty[w_rd_idx];
  assign w_last     = r_rcnt[w_rd_idx] >= cfg_reuse_i;
  assign rd_last_o  = w_last;
  assign mant_out_o = r_mant[w_rd_idx][r_head[w_rd_idx]];
  assign exp_out_o  = r_exp[w_rd_idx][r_head[w_rd_idx]];

  assign w_push = wr_valid_i & wr_ready_o;
  assign w_rd   = rd_valid_o & rd_ready_i;
  assign w_pop  = w_rd & w_last;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_empty[g]                 = (r_level[g] == '0);
      assign w_full[g]                  = (r_level[g] == c_depth_lv);
      assign w_push_v[g]                = w_push & (w_wr_idx == CH_W'(g));
      assign w_rd_v[g]                  = w_rd & (w_rd_idx == CH_W'(g));
      assign w_pop_v[g]                 = w_pop & (w_rd_idx == CH_W'(g));
      assign level_o[g*LV_W +: LV_W]    = r_level[g];
      assign almost_full_o[g]           = (r_level[g] >= c_afull_lv);
      assign almost_empty_o[g]          = (r_level[g] <= c_aempty_lv);
    end
  endgenerate

  assign empty_o = w_empty;
  assign full_o  = w_full;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_head[c]  <= '0;
        r_tail[c]  <= '0;
        r_level[c] <= '0;
        r_rcnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush_i[c]) begin
          r_head[c]  <= '0;
          r_tail[c]  <= '0;
          r_level[c] <= '0;
          r_rcnt[c]  <= '0;
        end else begin
          if (w_push_v[c]) begin
            r_tail[c] <= f_inc(r_tail[c]);
          end
          if (w_rd_v[c]) begin
            if (w_pop_v[c]) begin
              r_head[c] <= f_inc(r_head[c]);
              r_rcnt[c] <= '0;
            end else begin
              r_rcnt[c] <= r_rcnt[c] + REUSE_W'(1);
            end
          end
          // Level moves only when exactly one of push/pop happens.
          if (w_push_v[c] && !w_pop_v[c]) begin
            r_level[c] <= r_level[c] + LV_W'(1);
          end else if (w_pop_v[c] && !w_push_v[c]) begin
            r_level[c] <= r_level[c] - LV_W'(1);
          end
        end
      end
    end
  end

  // Storage carries no reset; data is only observable once rd_valid_o is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mant[w_wr_idx][r_tail[w_wr_idx]] <= mant_in_i;
      r_exp[w_wr_idx][r_tail[w_wr_idx]]  <= exp_in_i;
    end
  end

endmodule
`default_nettype wire
